// File: rtl/attention_stream_host.sv
// Host-side driver/collector for the attention engine: holds one Q/K/V operand
// set, streams it to the engine on start, captures the 64-word answer burst and
// exposes it through a registered read port with a running checksum.
module attention_stream_host #(
    parameter int N_ELEM  = 64,
    parameter int DATA_W  = 4,
    parameter int ANS_W   = 18,
    parameter int TIMEOUT = 1023,
    parameter int ADDR_W  = $clog2(N_ELEM),
    parameter int WAIT_W  = 10,
    parameter int CSUM_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_q,
    input  logic [DATA_W-1:0] wr_k,
    input  logic [DATA_W-1:0] wr_v,
    input  logic              start,
    output logic              busy,
    output logic              eng_reset,
    output logic              en,
    output logic [DATA_W-1:0] MATRIX_Q,
    output logic [DATA_W-1:0] MATRIX_K,
    output logic [DATA_W-1:0] MATRIX_V,
    input  logic              done,
    input  logic [ANS_W-1:0]  answer,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ANS_W-1:0]  rd_data,
    output logic              result_valid,
    output logic              timeout_err,
    output logic [CSUM_W-1:0] checksum
);

    localparam int                OP_W      = 3 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N_ELEM - 1);
    localparam logic [ADDR_W-1:0] ERST_LAST = ADDR_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ERST, S_LOAD, S_WAIT, S_CAPTURE, S_CMPLT, S_ERR
    } state_t;

    // Operand words are packed {q, k, v}; both memories are left uncleared by reset.
    logic [OP_W-1:0]  op_mem  [N_ELEM];
    logic [ANS_W-1:0] res_mem [N_ELEM];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              busy_q, busy_d;
    logic              eng_reset_q, eng_reset_d;
    logic              en_q, en_d;
    logic              result_valid_q, result_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CSUM_W-1:0] checksum_q, checksum_d;
    logic [OP_W-1:0]   op_rd_q;
    logic [ANS_W-1:0]  rd_data_q;

    logic              op_we;
    logic              op_rd_en;
    logic [ADDR_W-1:0] op_rd_idx;
    logic              res_we;

    // Next-state logic; the operand read is issued one cycle ahead so that the
    // registered MATRIX_* outputs line up with the registered en.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wait_d         = wait_q;
        busy_d         = busy_q;
        eng_reset_d    = eng_reset_q;
        en_d           = 1'b0;
        result_valid_d = result_valid_q;
        timeout_err_d  = timeout_err_q;
        checksum_d     = checksum_q;
        op_we          = wr_en && !busy_q;
        op_rd_en       = 1'b0;
        op_rd_idx      = cnt_q;
        res_we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                eng_reset_d = 1'b1;
                if (start) begin
                    result_valid_d = 1'b0;
                    timeout_err_d  = 1'b0;
                    checksum_d     = '0;
                    busy_d         = 1'b1;
                    cnt_d          = '0;
                    state_d        = S_ERST;
                end
            end
            S_ERST: begin
                if (cnt_q == ERST_LAST) begin
                    cnt_d       = '0;
                    eng_reset_d = 1'b0;
                    en_d        = 1'b1;
                    op_rd_en    = 1'b1;
                    op_rd_idx   = '0;
                    state_d     = S_LOAD;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            S_LOAD: begin
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    wait_d  = WAIT_W'(1);
                    state_d = S_WAIT;
                end else begin
                    cnt_d     = cnt_q + ADDR_W'(1);
                    en_d      = 1'b1;
                    op_rd_en  = 1'b1;
                    op_rd_idx = cnt_q + ADDR_W'(1);
                end
            end
            S_WAIT: begin
                // wait_q counts cycles elapsed since the last en cycle
                if (done) begin
                    res_we     = 1'b1;
                    checksum_d = checksum_q + CSUM_W'(answer);
                    cnt_d      = ADDR_W'(1);
                    state_d    = S_CAPTURE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    eng_reset_d   = 1'b1;
                    state_d       = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_CAPTURE: begin
                if (done) begin
                    res_we     = 1'b1;
                    checksum_d = checksum_q + CSUM_W'(answer);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d          = '0;
                        result_valid_d = 1'b1;
                        busy_d         = 1'b0;
                        eng_reset_d    = 1'b1;
                        state_d        = S_CMPLT;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end else begin
                    // burst ended early: protocol error
                    timeout_err_d = 1'b1;
                    busy_d        = 1'b0;
                    eng_reset_d   = 1'b1;
                    state_d       = S_ERR;
                end
            end
            S_CMPLT, S_ERR: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wait_q         <= '0;
            busy_q         <= 1'b0;
            eng_reset_q    <= 1'b1;
            en_q           <= 1'b0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
            checksum_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wait_q         <= wait_d;
            busy_q         <= busy_d;
            eng_reset_q    <= eng_reset_d;
            en_q           <= en_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
            checksum_q     <= checksum_d;
        end
    end

    // Operand RAM write port, frozen while a run is in progress.
    always_ff @(posedge clk) begin
        if (reset && op_we) begin
            op_mem[wr_addr] <= {wr_q, wr_k, wr_v};
        end
    end

    // Operand RAM read register doubles as the MATRIX_* output register; zero outside LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_rd_q <= '0;
        end else if (op_rd_en) begin
            op_rd_q <= op_mem[op_rd_idx];
        end else begin
            op_rd_q <= '0;
        end
    end

    // Result RAM write port, fed by the capture counter.
    always_ff @(posedge clk) begin
        if (reset && res_we) begin
            res_mem[cnt_q] <= answer;
        end
    end

    // Result RAM registered read; a same-cycle capture returns the old word.
    always_ff @(posedge clk) begin
        rd_data_q <= res_mem[rd_addr];
    end

    assign busy         = busy_q;
    assign eng_reset    = eng_reset_q;
    assign en           = en_q;
    assign MATRIX_Q     = op_rd_q[OP_W-1 -: DATA_W];
    assign MATRIX_K     = op_rd_q[2*DATA_W-1 -: DATA_W];
    assign MATRIX_V     = op_rd_q[DATA_W-1:0];
    assign rd_data      = rd_data_q;
    assign result_valid = result_valid_q;
    assign timeout_err  = timeout_err_q;
    assign checksum     = checksum_q;

endmodule

// File: tb/tb_attention_stream_host.sv
// Bench for attention_stream_host: engine stub computing (Q*K^T)*V on 8x8
// matrices, an operand-stream scoreboard and a read-port scoreboard.
module tb_attention_stream_host;

    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [3:0]  wr_q = '0, wr_k = '0, wr_v = '0;
    logic        start = 1'b0;
    logic        busy, eng_reset, en;
    logic [3:0]  MATRIX_Q, MATRIX_K, MATRIX_V;
    logic        done = 1'b0;
    logic [17:0] answer = '0;
    logic [5:0]  rd_addr = '0;
    logic [17:0] rd_data;
    logic        result_valid, timeout_err;
    logic [23:0] checksum;

    attention_stream_host dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_q(wr_q), .wr_k(wr_k), .wr_v(wr_v), .start(start),
        .busy(busy), .eng_reset(eng_reset), .en(en),
        .MATRIX_Q(MATRIX_Q), .MATRIX_K(MATRIX_K), .MATRIX_V(MATRIX_V),
        .done(done), .answer(answer), .rd_addr(rd_addr), .rd_data(rd_data),
        .result_valid(result_valid), .timeout_err(timeout_err), .checksum(checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: out[r][c] = sum_j (sum_t Q[r][t]*K[j][t]) * V[j][c], row-major 8x8
    function automatic int attn(input logic [3:0] q [64], input logic [3:0] k [64],
                                input logic [3:0] v [64], input int i);
        int r = i / 8;
        int c = i % 8;
        int s = 0;
        for (int j = 0; j < 8; j++) begin
            int a = 0;
            for (int t = 0; t < 8; t++) a += int'(q[r*8+t]) * int'(k[j*8+t]);
            s += a * int'(v[j*8+c]);
        end
        return s;
    endfunction

    logic [3:0] ref_q [64];
    logic [3:0] ref_k [64];
    logic [3:0] ref_v [64];

    function automatic logic [31:0] exp_sum(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += attn(ref_q, ref_k, ref_v, i);
        return 32'(s) & 32'h00FF_FFFF;
    endfunction

    // Engine stub: collects the 64-element stream, waits a few cycles, then bursts answers.
    // mode 0: 64 words, 1: never done, 2: drop after 10, 3: 66 words (2 junk extras)
    int         stub_mode = 0;
    logic [3:0] sq [64];
    logic [3:0] sk [64];
    logic [3:0] sv [64];
    int         col_n = 0, gap_cnt = 0, out_i = 0;
    logic       emitting = 1'b0;

    function automatic int stub_limit(input int m);
        return (m == 2) ? 10 : (m == 3) ? 66 : 64;
    endfunction

    always @(posedge clk) begin
        done <= 1'b0;
        if (eng_reset === 1'b1) begin
            col_n <= 0; gap_cnt <= 0; out_i <= 0; emitting <= 1'b0;
        end else begin
            if (en === 1'b1 && col_n < 64) begin
                sq[col_n] <= MATRIX_Q; sk[col_n] <= MATRIX_K; sv[col_n] <= MATRIX_V;
                col_n <= col_n + 1;
            end
            if (col_n == 64 && !emitting && out_i == 0) begin
                if (gap_cnt == 4) emitting <= 1'b1;
                else gap_cnt <= gap_cnt + 1;
            end
            if (emitting) begin
                if (stub_mode != 1 && out_i < stub_limit(stub_mode)) begin
                    done   <= 1'b1;
                    answer <= (out_i >= 64) ? 18'h3FFFF : 18'(attn(sq, sk, sv, out_i));
                    out_i  <= out_i + 1;
                end else begin
                    emitting <= 1'b0;
                end
            end
        end
    end

    // Scoreboards
    logic [11:0] exp_stream [$];
    typedef struct { int cyc; int addr; logic [17:0] exp; } rd_t;
    rd_t rd_pend [$];

    int en_count = 0, en_rise_cyc = -1, last_en_cyc = -1, to_rise_cyc = -1;

    // Monitor: pops expected operand triples on en, checks reads one cycle after issue.
    initial begin
        logic [11:0] e;
        logic        prev_en;
        logic        prev_to;
        rd_t         rq;
        prev_en = 1'b0;
        prev_to = 1'b0;
        forever begin
            @(negedge clk);
            if (en === 1'b1) begin
                if (!prev_en) en_rise_cyc = cyc;
                en_count++;
                last_en_cyc = cyc;
                chk("en_expected", 32'(exp_stream.size() > 0), 1);
                if (exp_stream.size() > 0) begin
                    e = exp_stream.pop_front();
                    chk("stream_qkv", {20'd0, MATRIX_Q, MATRIX_K, MATRIX_V}, {20'd0, e});
                end
            end else if (prev_en) begin
                chk("matrix_zero_after_en", {20'd0, MATRIX_Q, MATRIX_K, MATRIX_V}, 0);
            end
            if (timeout_err === 1'b1 && !prev_to) to_rise_cyc = cyc;
            prev_en = (en === 1'b1);
            prev_to = (timeout_err === 1'b1);
            if (rd_pend.size() > 0 && rd_pend[0].cyc == cyc - 1) begin
                rq = rd_pend.pop_front();
                chk($sformatf("rd_data[%0d]", rq.addr), {14'd0, rd_data}, {14'd0, rq.exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind 0: all elements = val, kind 1: random
    task automatic load_all(input int kind, input int val);
        for (int i = 0; i < 64; i++) begin
            step();
            wr_en = 1'b1; wr_addr = 6'(i);
            wr_q = (kind == 0) ? 4'(val) : 4'($urandom_range(0, 15));
            wr_k = (kind == 0) ? 4'(val) : 4'($urandom_range(0, 15));
            wr_v = (kind == 0) ? 4'(val) : 4'($urandom_range(0, 15));
            ref_q[i] = wr_q; ref_k[i] = wr_k; ref_v[i] = wr_v;
        end
        step();
        wr_en = 1'b0;
    endtask

    int start_cyc = 0;

    task automatic do_start(input bit with_wr, input int a, input int q, input int k, input int v);
        step();
        if (with_wr) begin
            wr_en = 1'b1; wr_addr = 6'(a); wr_q = 4'(q); wr_k = 4'(k); wr_v = 4'(v);
            ref_q[a] = 4'(q); ref_k[a] = 4'(k); ref_v[a] = 4'(v);
        end
        start = 1'b1;
        start_cyc = cyc;
        en_count = 0; en_rise_cyc = -1; to_rise_cyc = -1;
        for (int i = 0; i < 64; i++) exp_stream.push_back({ref_q[i], ref_k[i], ref_v[i]});
        step();
        start = 1'b0;
        wr_en = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk("run_ends_in_budget", 32'(n < maxc), 1);
    endtask

    // Called at the negedge where busy has just dropped
    task automatic check_end(input string tag, input logic rv, input logic te, input logic [31:0] cs);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_result_valid"}, 32'(result_valid), 32'(rv));
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'(te));
        chk({tag, "_checksum"}, {8'd0, checksum}, cs);
        chk({tag, "_stream_drained"}, 32'(exp_stream.size()), 0);
        step();
        step();
    endtask

    task automatic rd_check(input int a);
        step();
        rd_addr = 6'(a);
        rd_pend.push_back('{cyc, a, 18'(attn(ref_q, ref_k, ref_v, a))});
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_eng_reset", 32'(eng_reset), 1);
        chk("rst_en", 32'(en), 0);
        chk("rst_matrix", {20'd0, MATRIX_Q, MATRIX_K, MATRIX_V}, 0);
        chk("rst_result_valid", 32'(result_valid), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_checksum", {8'd0, checksum}, 0);
        step();
        reset = 1'b1;

        // all ones: every answer 64, checksum 4096
        stub_mode = 0;
        load_all(0, 1);
        do_start(0, 0, 0, 0, 0);
        wait_done(300);
        chk("t1_start_to_en", 32'(en_rise_cyc - start_cyc), 3);
        chk("t1_en_count", 32'(en_count), 64);
        check_end("t1", 1'b1, 1'b0, 32'd4096);
        rd_check(5);

        // all 15: every answer 216000, checksum 13824000
        load_all(0, 15);
        do_start(0, 0, 0, 0, 0);
        wait_done(300);
        check_end("t2", 1'b1, 1'b0, 32'd13824000);
        rd_check(63);

        // no done: timeout exactly TO cycles after last en
        stub_mode = 1;
        load_all(1, 0);
        do_start(0, 0, 0, 0, 0);
        wait_done(1500);
        chk("t3_timeout_latency", 32'(to_rise_cyc - last_en_cyc), TO);
        check_end("t3", 1'b0, 1'b1, 0);

        // done drops after 10 words
        stub_mode = 2;
        load_all(1, 0);
        do_start(0, 0, 0, 0, 0);
        wait_done(300);
        check_end("t4", 1'b0, 1'b1, exp_sum(10));
        rd_check(9);

        // start and write during LOAD are ignored; 2 surplus done words ignored
        stub_mode = 3;
        load_all(1, 0);
        step();
        wr_en = 1'b1; wr_addr = 6'd3; wr_q = 4'd2; wr_k = ref_k[3]; wr_v = ref_v[3];
        ref_q[3] = 4'd2;
        step();
        wr_en = 1'b0;
        do_start(0, 0, 0, 0, 0);
        while (cyc < start_cyc + 13) step();
        start = 1'b1; wr_en = 1'b1; wr_addr = 6'd3; wr_q = 4'd7;
        step();
        start = 1'b0; wr_en = 1'b0;
        wait_done(300);
        chk("t5_en_count", 32'(en_count), 64);
        check_end("t5", 1'b1, 1'b0, exp_sum(64));
        repeat (12) step();
        chk("t5_no_second_run", 32'(en_count), 64);
        rd_check(0);
        rd_check(1);
        stub_mode = 0;
        do_start(0, 0, 0, 0, 0);
        wait_done(300);
        check_end("t5b", 1'b1, 1'b0, exp_sum(64));

        // reset mid-LOAD at element 20, then restart with a same-cycle write
        do_start(0, 0, 0, 0, 0);
        while (cyc < start_cyc + 23) step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6_elements_streamed", 32'(exp_stream.size()), 43);
        exp_stream.delete();
        @(negedge clk);
        chk("t6_en", 32'(en), 0);
        chk("t6_eng_reset", 32'(eng_reset), 1);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_checksum", {8'd0, checksum}, 0);
        chk("t6_result_valid", 32'(result_valid), 0);
        do_start(1, 0, 9, 14, 5);
        wait_done(300);
        chk("t6_en_count", 32'(en_count), 64);
        check_end("t6", 1'b1, 1'b0, exp_sum(64));
        rd_check(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/attention_stream_host.md
Name: attention_stream_host

Overview:
- Host-side driver and collector for the transformer attention engine.
- Holds one Q/K/V operand set (64 elements each, 4-bit) written by a control port. On `start` it resets the engine, streams the operands over the engine's `en`/`MATRIX_*` interface, then captures the 64-word 18-bit `answer` burst qualified by `done`.
- Captured results are readable by address, with a running checksum and a timeout flag.
- Sits between the control/test logic and the attention engine instance.

Parameters:
- N_ELEM, 64, elements per matrix and answers per burst; power of two.
- DATA_W, 4, operand width.
- ANS_W, 18, answer width.
- TIMEOUT, 1023, maximum WAIT cycles before the run aborts.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low reset.
- `wr_en` in 1: operand write strobe.
- `wr_addr` in 6: operand element index.
- `wr_q`, `wr_k`, `wr_v` in 4 each: operand values.
- `start` in 1: single-cycle run request.
- `busy` out 1: high from accepted `start` until the run reaches CMPLT or ERR.
- `eng_reset` out 1: active-high reset to the engine.
- `en` out 1: engine input-valid.
- `MATRIX_Q`, `MATRIX_K`, `MATRIX_V` out 4 each: engine operands.
- `done` in 1: engine output-valid.
- `answer` in 18: engine result.
- `rd_addr` in 6: result read index.
- `rd_data` out 18: result read data.
- `result_valid` out 1: all 64 results captured.
- `timeout_err` out 1: run aborted on timeout.
- `checksum` out 24: sum of captured answers, mod 2^24.

Behaviour:
- **Reset (`reset`=0 at posedge).** Enters IDLE.
  - Outputs: `busy`=0, `eng_reset`=1, `en`=0, `MATRIX_*`=0, `result_valid`=0, `timeout_err`=0, `checksum`=0.
  - Counters are cleared. Operand and result RAMs are not cleared.
  - Reset mid-run aborts immediately; no further `en` is driven.
- **IDLE.** `eng_reset`=1.
  - `wr_en`=1 writes `wr_q`/`wr_k`/`wr_v` to index `wr_addr` at the clock edge.
  - `start`=1 clears `result_valid`, `timeout_err` and `checksum`, sets `busy`, and moves to ERST.
  - If `wr_en` and `start` occur in the same cycle, the write lands first and the run uses the new data.
- **Writes outside IDLE.** `wr_en` is ignored while `busy`, so operands are frozen during a run.
- **Start outside IDLE.** `start` while `busy`=1 is ignored.
- **ERST.** `eng_reset`=1 for exactly 2 cycles, then `eng_reset`=0 and go to LOAD.
- **LOAD.** `en`=1 for exactly 64 consecutive cycles.
  - Cycle i (0..63) drives `MATRIX_Q`/`MATRIX_K`/`MATRIX_V` = operand[i], registered outputs aligned with `en`.
  - After element 63: `en`=0, `MATRIX_*`=0, go to WAIT.
- **WAIT.** The wait counter increments each cycle.
  - `done`=1 moves to CAPTURE and captures `answer` as word 0 in that same cycle.
  - If the counter reaches TIMEOUT with no `done`: `timeout_err`=1, `busy`=0, `eng_reset`=1, go to ERR.
- **CAPTURE.** Each cycle with `done`=1: `result[cnt]` ← `answer`, `checksum` += `answer` (zero-extended, wraps mod 2^24), `cnt`++.
  - After word 63 is stored: go to CMPLT the next cycle.
  - `done` dropping before 64 words is a protocol error: `timeout_err`=1, go to ERR, `result_valid` stays 0.
  - `done` beyond 64 words is ignored.
- **CMPLT.** `result_valid`=1, `busy`=0, `eng_reset`=1, return to IDLE on the next cycle.
  - `result_valid` stays high until the next accepted `start` or `reset`.
- **ERR.** Same as CMPLT but `result_valid`=0 and `timeout_err` is held. Returns to IDLE the next cycle.
- **Read port.** `rd_data` = `result[rd_addr]`, registered, 1-cycle latency, readable in any state.
  - Reading an index in the same cycle it is captured returns the old value.
- **Widths.**
  - All element counters are 6-bit; wrap at 63 is terminal, with no rollover into a second pass.
  - The wait counter is 10-bit.
- **Latency.** `start` to first `en` = 3 cycles (1 cycle into ERST, plus 2 ERST cycles).

Test Plan:
1. Load all Q=K=V=1, `start` → `en` high for exactly 64 cycles beginning 3 cycles after `start`. With the engine model every answer=64: `result_valid`=1, `checksum`=4096, `rd_addr`=5 gives `rd_data`=64 one cycle later.
2. Load Q=K=V=15 → answers saturate the width: each answer = 8·(8·225)·15 = 216000 (0x34BC0). `checksum`=(64·216000) mod 2^24 = 13824000.
3. Engine stub never asserts `done` → `timeout_err`=1 exactly TIMEOUT cycles after the last `en`, `busy`=0, `result_valid`=0.
4. Stub drops `done` after 10 words → `timeout_err`=1, `result_valid`=0. `rd_data` at index 9 holds the 10th answer.
5. Pulse `start` and `wr_en` at address 3 with Q=7 during LOAD → no second run and operand[3] unchanged. The next run drives Q[3]=original value.
6. Deassert `reset` mid-LOAD at element 20 → the next cycle `en`=0, `eng_reset`=1, `busy`=0, `checksum`=0. A new `start` re-streams from element 0.
